zmod_rxpll_ctrl: RTL and testbench



---
 rtl/zmod_rxpll_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_zmod_rxpll_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zmod_rxpll_ctrl.sv
// -----------------------------------------------------------------------------
// zmod_rxpll_ctrl
//
// Bring-up and supervision controller for the ZMOD receive-clock PLL.
// Sequences the PLL reset, waits for and qualifies LOCKED, releases the
// downstream receive-path reset, and recovers from lock loss with a bounded
// number of retries. Runs on a free-running fabric clock that is never
// derived from the supervised PLL.
//
// Ports:
//   clk             in   free-running controller clock
//   resetn          in   asynchronous active-low reset
//   enable          in   1 = bring up and keep the PLL running, 0 = hold reset
//   pll_locked      in   raw PLL LOCKED, asynchronous to clk
//   pll_rst         out  PLL RST, active high
//   rx_rst          out  receive-path (ISERDES/capture) reset, active high
//   ready           out  receive clocks qualified, capture may run
//   fault           out  lock retries exhausted
//   retry_count     out  lock timeouts seen in the current bring-up
//   lock_loss_count out  lock losses seen while running (saturating)
//   state           out  current FSM state for debug
//                        (IDLE=0 RESET=1 WAIT_LOCK=2 SETTLE=3 RUN=4 FAULT=5)
// -----------------------------------------------------------------------------
module zmod_rxpll_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8,
  localparam int RETRY_W = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               rx_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [CNT_W-1:0]   lock_loss_count,
  output logic [2:0]         state
);

  // The shared counter must cover the longest per-state interval.
  localparam int CTR_MAX =
    (LOCK_TIMEOUT > RST_CYCLES) ?
      ((LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES) :
      ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
  localparam int CTR_W = $clog2(CTR_MAX + 1);

  localparam logic [CTR_W-1:0]   RST_LAST     = CTR_W'(RST_CYCLES - 1);
  localparam logic [CTR_W-1:0]   TIMEOUT_LAST = CTR_W'(LOCK_TIMEOUT - 1);
  localparam logic [CTR_W-1:0]   SETTLE_LAST  = CTR_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_SETTLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic               sync1_q, sync1_d;
  logic               locked_s_q, locked_s_d;
  logic               pll_rst_q, pll_rst_d;
  logic               rx_rst_q, rx_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    loss_d     = loss_q;
    cnt_d      = cnt_q;
    // Two-flop synchronizer for the asynchronous LOCKED input.
    sync1_d    = pll_locked;
    locked_s_d = sync1_q;

    // Dropping enable overrides every other transition, so no counter
    // moves on the edge where it is seen.
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RESET;
          retry_d = '0;
        end
        S_RESET: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = S_SETTLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAULT;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET;
            end
          end
        end
        S_SETTLE: begin
          // Any low cycle restarts the lock wait; the counter clear on the
          // state change restarts the timeout from zero.
          if (!locked_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            if (loss_q != '1) loss_d = loss_q + 1'b1;
            retry_d = '0;
            state_d = S_RESET;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Shared counter: clears on every state change, otherwise counts up and
    // parks at all-ones in states that never look at it.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    pll_rst_d = (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_FAULT);
    rx_rst_d  = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      pll_rst_q  <= 1'b1;
      rx_rst_q   <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      sync1_q    <= sync1_d;
      locked_s_q <= locked_s_d;
      pll_rst_q  <= pll_rst_d;
      rx_rst_q   <= rx_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign rx_rst          = rx_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign state           = state_q;

endmodule

// File: tb/tb_zmod_rxpll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_zmod_rxpll_ctrl
//
// Self-checking bench for zmod_rxpll_ctrl. A behavioural model (phase plus
// time-in-phase, LOCKED delayed through a sample queue) predicts every output
// on every clock; on top of that a vector table and hand-written sequences
// check the bring-up, retry, glitch, lock-loss, enable-drop and reset cases
// against hand-derived constants. Ends with a randomized soak.
// -----------------------------------------------------------------------------
module tb_zmod_rxpll_ctrl;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 32;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 2;
  localparam int RW = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2;
  localparam int LOSS_MAX = (1 << CNT_W) - 1;

  localparam int P_IDLE = 0, P_RESET = 1, P_WAIT = 2, P_SETTLE = 3, P_RUN = 4, P_FAULT = 5;

  logic             clk = 1'b0;
  logic             resetn;
  logic             enable;
  logic             pll_locked;
  logic             pll_rst;
  logic             rx_rst;
  logic             ready;
  logic             fault;
  logic [RW-1:0]    retry_count;
  logic [CNT_W-1:0] lock_loss_count;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  zmod_rxpll_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRIES  (MAX_RETRIES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .rx_rst         (rx_rst),
    .ready          (ready),
    .fault          (fault),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .state          (state)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_phase, m_spent, m_retry, m_loss;
  bit m_dly[$];          // LOCKED samples still travelling to the controller
  bit m_prst_of[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  function automatic void model_reset();
    m_phase = P_IDLE;
    m_spent = 0;
    m_retry = 0;
    m_loss  = 0;
    m_dly   = '{1'b0, 1'b0};
  endfunction

  function automatic void model_step(bit en, bit pl);
    bit seen;
    int nxt;
    seen = m_dly.pop_front();
    m_dly.push_back(pl);
    m_spent = m_spent + 1;     // edges completed in the current phase
    nxt = m_phase;
    if (!en) begin
      nxt = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE:   begin nxt = P_RESET; m_retry = 0; end
        P_RESET:  if (m_spent == RST_CYCLES) nxt = P_WAIT;
        P_WAIT: begin
          if (seen) nxt = P_SETTLE;
          else if (m_spent == LOCK_TIMEOUT) begin
            if (m_retry == MAX_RETRIES) nxt = P_FAULT;
            else begin m_retry = m_retry + 1; nxt = P_RESET; end
          end
        end
        P_SETTLE: begin
          if (!seen) nxt = P_WAIT;
          else if (m_spent == SETTLE_CYCLES) nxt = P_RUN;
        end
        P_RUN: begin
          if (!seen) begin
            m_loss  = (m_loss >= LOSS_MAX) ? LOSS_MAX : m_loss + 1;
            m_retry = 0;
            nxt     = P_RESET;
          end
        end
        default: ;
      endcase
    end
    if (nxt != m_phase) m_spent = 0;
    m_phase = nxt;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_state",   int'(state),           m_phase);
    chk("model_pll_rst", int'(pll_rst),         int'(m_prst_of[m_phase]));
    chk("model_rx_rst",  int'(rx_rst),          (m_phase != P_RUN) ? 1 : 0);
    chk("model_ready",   int'(ready),           (m_phase == P_RUN) ? 1 : 0);
    chk("model_fault",   int'(fault),           (m_phase == P_FAULT) ? 1 : 0);
    chk("model_retry",   int'(retry_count),     m_retry);
    chk("model_loss",    int'(lock_loss_count), m_loss);
  endtask

  // One clock: advance the model with what the DUT sampled, then compare 1ns
  // after the edge.
  task automatic tick();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step(enable, pll_locked);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic check_idle(input string name);
    chk({name, "_state"},   int'(state),   P_IDLE);
    chk({name, "_pll_rst"}, int'(pll_rst), 1);
    chk({name, "_rx_rst"},  int'(rx_rst),  1);
    chk({name, "_ready"},   int'(ready),   0);
    $display("%s: state=%0d pll_rst=%0b rx_rst=%0b ready=%0b", name, state, pll_rst, rx_rst, ready);
  endtask

  task automatic wait_state(input int target, input int bound, input string name);
    int n = 0;
    while (int'(state) != target && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_reached"}, int'(state), target);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the normal bring-up
  // ---------------------------------------------------------------------------
  typedef struct {
    bit en;
    bit pl;
    int n;
    int st;
    bit prst;
    bit rxr;
    bit rdy;
    bit flt;
    int rty;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end, required end");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_prst, bad_rty, saw_ready, bad_st, lat, width, n;
    int run_left;

    // enable, pll_locked, ticks, then state/pll_rst/rx_rst/ready/fault/retry.
    vt[0] = '{1'b1, 1'b0, 1,  P_RESET,  1'b1, 1'b1, 1'b0, 1'b0, 0}; // RESET entry
    vt[1] = '{1'b1, 1'b0, 3,  P_RESET,  1'b1, 1'b1, 1'b0, 1'b0, 0}; // 4th RESET cycle
    vt[2] = '{1'b1, 1'b0, 1,  P_WAIT,   1'b0, 1'b1, 1'b0, 1'b0, 0}; // pll_rst falls
    vt[3] = '{1'b1, 1'b0, 10, P_WAIT,   1'b0, 1'b1, 1'b0, 1'b0, 0}; // 10 cycles no lock
    vt[4] = '{1'b1, 1'b1, 2,  P_WAIT,   1'b0, 1'b1, 1'b0, 1'b0, 0}; // in synchronizer
    vt[5] = '{1'b1, 1'b1, 1,  P_SETTLE, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // SETTLE entry
    vt[6] = '{1'b1, 1'b1, 7,  P_SETTLE, 1'b0, 1'b1, 1'b0, 1'b0, 0}; // 10 after lock
    vt[7] = '{1'b1, 1'b1, 1,  P_RUN,    1'b0, 1'b0, 1'b1, 1'b0, 0}; // 11 after lock

    // ---- reset values ----
    resetn = 1'b0; enable = 1'b0; pll_locked = 1'b0;
    model_reset();
    #2;
    repeat (3) tick();
    chk("rst_state",   int'(state),           P_IDLE);
    chk("rst_pll_rst", int'(pll_rst),         1);
    chk("rst_rx_rst",  int'(rx_rst),          1);
    chk("rst_ready",   int'(ready),           0);
    chk("rst_fault",   int'(fault),           0);
    chk("rst_retry",   int'(retry_count),     0);
    chk("rst_loss",    int'(lock_loss_count), 0);
    resetn = 1'b1;
    tick();
    chk("idle_after_reset", int'(state), P_IDLE);

    // ---- 1: normal bring-up, table driven ----
    for (int r = 0; r < 8; r++) begin
      enable = vt[r].en;
      pll_locked = vt[r].pl;
      repeat (vt[r].n) tick();
      chk($sformatf("t1_row%0d_state", r),   int'(state),       vt[r].st);
      chk($sformatf("t1_row%0d_pll_rst", r), int'(pll_rst),     int'(vt[r].prst));
      chk($sformatf("t1_row%0d_rx_rst", r),  int'(rx_rst),      int'(vt[r].rxr));
      chk($sformatf("t1_row%0d_ready", r),   int'(ready),       int'(vt[r].rdy));
      chk($sformatf("t1_row%0d_fault", r),   int'(fault),       int'(vt[r].flt));
      chk($sformatf("t1_row%0d_retry", r),   int'(retry_count), vt[r].rty);
      $display("t1 row %0d: state=%0d pll_rst=%0b rx_rst=%0b ready=%0b retry=%0d",
               r, state, pll_rst, rx_rst, ready, retry_count);
    end

    // ---- 2: no lock, three attempts then FAULT ----
    enable = 1'b0; pll_locked = 1'b0;
    tick();
    check_idle("t2_pre_idle");
    enable = 1'b1;
    bad_prst = 0; bad_rty = 0; saw_ready = 0;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (i <= 3 * (RST_CYCLES + LOCK_TIMEOUT)) begin
        if (int'(pll_rst) != ((((i - 1) % (RST_CYCLES + LOCK_TIMEOUT)) < RST_CYCLES) ? 1 : 0)) bad_prst++;
        if (int'(retry_count) != (i - 1) / (RST_CYCLES + LOCK_TIMEOUT)) bad_rty++;
        if (fault) bad_prst++;
      end else begin
        if (!pll_rst || !fault) bad_prst++;
        if (int'(retry_count) != MAX_RETRIES) bad_rty++;
      end
      if (ready) saw_ready++;
    end
    chk("t2_pll_rst_pattern", bad_prst, 0);
    chk("t2_retry_pattern",   bad_rty,  0);
    chk("t2_ready_never",     saw_ready, 0);
    chk("t2_fault",           int'(fault), 1);
    chk("t2_fault_state",     int'(state), P_FAULT);
    $display("t2 no-lock: fault=%0b retry=%0d state=%0d", fault, retry_count, state);
    enable = 1'b0;
    tick();
    chk("t2_fault_cleared", int'(fault), 0);
    check_idle("t2_exit");

    // ---- 3: lock glitch during SETTLE ----
    enable = 1'b1; pll_locked = 1'b1;
    bad_st = 0;
    for (int t = 1; t <= 20; t++) begin
      int exp_st;
      tick();
      exp_st = (t <= 4) ? P_RESET : (t == 5) ? P_WAIT : (t <= 10) ? P_SETTLE :
               (t == 11) ? P_WAIT : (t <= 19) ? P_SETTLE : P_RUN;
      if (int'(state) != exp_st) bad_st++;
      if (t == 19) chk("t3_ready_not_yet", int'(ready), 0);
      if (t == 8) pll_locked = 1'b0;
      if (t == 9) pll_locked = 1'b1;
    end
    chk("t3_state_sequence", bad_st, 0);
    chk("t3_ready",          int'(ready), 1);
    chk("t3_retry",          int'(retry_count), 0);
    $display("t3 glitch: state=%0d ready=%0b retry=%0d", state, ready, retry_count);

    // ---- 4: repeated lock loss in RUN ----
    for (int k = 0; k < 4; k++) begin
      pll_locked = 1'b0;
      lat = 0;
      while (ready && lat < 10) begin
        tick();
        lat++;
      end
      chk("t4_ready_drop_within_3", (lat <= 3) ? 1 : 0, 1);
      chk("t4_pll_rst_on_loss", int'(pll_rst), 1);
      chk("t4_rx_rst_on_loss",  int'(rx_rst),  1);
      pll_locked = 1'b1;
      width = 1;
      n = 0;
      while (n < 20) begin
        tick();
        n++;
        if (!pll_rst) break;
        width++;
      end
      chk("t4_pll_rst_width", width, RST_CYCLES);
      chk("t4_loss_count", int'(lock_loss_count), (k + 1 > LOSS_MAX) ? LOSS_MAX : k + 1);
      wait_state(P_RUN, 60, "t4_relock");
      $display("t4 loss %0d: latency=%0d pulse=%0d lock_loss_count=%0d", k, lat, width, lock_loss_count);
    end

    // ---- 5: enable drop in RUN, WAIT_LOCK, SETTLE and at timeout ----
    enable = 1'b0;
    tick();
    check_idle("t5_run_drop");
    enable = 1'b1; pll_locked = 1'b0;
    wait_state(P_WAIT, 20, "t5_to_wait");
    enable = 1'b0;
    tick();
    check_idle("t5_wait_drop");
    enable = 1'b1; pll_locked = 1'b1;
    wait_state(P_SETTLE, 20, "t5_to_settle");
    enable = 1'b0;
    tick();
    check_idle("t5_settle_drop");
    enable = 1'b1; pll_locked = 1'b0;
    wait_state(P_WAIT, 20, "t5_to_wait2");
    repeat (LOCK_TIMEOUT - 1) tick();
    chk("t5_still_waiting", int'(state), P_WAIT);
    enable = 1'b0;                  // lands on the timeout edge
    tick();
    check_idle("t5_timeout_drop");
    chk("t5_timeout_no_retry", int'(retry_count), 0);

    // resetn during RUN
    enable = 1'b1; pll_locked = 1'b1;
    wait_state(P_RUN, 60, "t5_to_run");
    #3;
    resetn = 1'b0;
    #1;
    chk("t5_arst_state",   int'(state),           P_IDLE);
    chk("t5_arst_pll_rst", int'(pll_rst),         1);
    chk("t5_arst_rx_rst",  int'(rx_rst),          1);
    chk("t5_arst_ready",   int'(ready),           0);
    chk("t5_arst_fault",   int'(fault),           0);
    chk("t5_arst_retry",   int'(retry_count),     0);
    chk("t5_arst_loss",    int'(lock_loss_count), 0);
    $display("t5 async reset: state=%0d lock_loss_count=%0d", state, lock_loss_count);
    model_reset();
    repeat (2) tick();
    resetn = 1'b1;

    // enable drop coinciding with lock loss: IDLE wins, no count
    wait_state(P_RUN, 60, "t5_to_run2");
    pll_locked = 1'b0;
    repeat (2) tick();
    enable = 1'b0;
    tick();
    check_idle("t5_loss_drop");
    chk("t5_loss_not_counted", int'(lock_loss_count), 0);
    enable = 1'b1; pll_locked = 1'b1;
    wait_state(P_RUN, 60, "t5_to_run3");
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("t5_loss_counted", int'(lock_loss_count), 1);

    // ---- randomized soak against the model ----
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        pll_locked = ~pll_locked;
        run_left = pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 130));
      end
      run_left--;
      enable = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      tick();
    end
    $display("random soak: %0d cycles, lock_loss_count=%0d", 3000, lock_loss_count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
